demux_stream: RTL

//   Parametrised 1-to-NCH stream demultiplexer, successor to the 1:4 behavioural demux.
//   A single W-bit input stream carries a per-beat channel select. Each beat is routed
//   to one of NCH registered output slots, with valid/ready handshakes on both sides.

---
 rtl/demux_stream_if.sv | 36 +++
 rtl/demux_stream.sv | 81 ++++++++
 2 files changed

// File: rtl/demux_stream_if.sv
// demux_stream_if: handshake bundle between a shared producer, the demux and its NCH consumers
// The cnt/cnt_clr signals exist only when DEMUX_CNT_EN is defined.
interface demux_stream_if #(
    parameter int W   = 1,
    parameter int NCH = 4
);
    localparam int SELW = $clog2(NCH);
    logic [W-1:0]     in_data;
    logic [SELW-1:0]  in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [NCH*W-1:0] out_data;
    logic [NCH-1:0]   out_valid;
    logic [NCH-1:0]   out_ready;
    logic             err_sel;
`ifdef DEMUX_CNT_EN
    logic [NCH*8-1:0] cnt;
    logic             cnt_clr;
`endif
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, err_sel
`ifdef DEMUX_CNT_EN
        , output cnt_clr
        , input  cnt
`endif
    );
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, err_sel
`ifdef DEMUX_CNT_EN
        , input  cnt_clr
        , output cnt
`endif
    );
endinterface

// File: rtl/demux_stream.sv
// demux_stream: 1-to-NCH registered stream demultiplexer with per-slot valid/ready
// Per-channel saturating delivery counters are built only when DEMUX_CNT_EN is defined.
module demux_stream #(
    parameter int W   = 1,
    parameter int NCH = 4
) (
    input logic           clk,
    input logic           rst_n,
    demux_stream_if.slave bus
);
    localparam int SELW = $clog2(NCH);
    localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

    typedef enum logic {EMPTY, FULL} slot_t;

    slot_t                 state_q [NCH];
    slot_t                 state_d [NCH];
    logic [NCH-1:0][W-1:0] data_q;
    logic [NCH-1:0]        valid;
    logic [NCH-1:0]        deliver;
    logic [NCH-1:0]        load;
    logic                  sel_ok;
    logic                  take;
    logic                  err_q;

    // Selects past NCH are always accepted so a bad beat can never stall the producer.
    assign sel_ok       = {1'b0, bus.in_sel} < NCH_L;
    assign bus.in_ready = sel_ok ? (!valid[bus.in_sel] | bus.out_ready[bus.in_sel]) : 1'b1;
    assign take         = bus.in_valid & bus.in_ready;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            valid[i] = state_q[i] == FULL;
        end
    end

    // A reload in the same cycle as a delivery keeps the slot FULL.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            deliver[i] = valid[i] & bus.out_ready[i];
            load[i]    = take & sel_ok & (bus.in_sel == SELW'(i));
            state_d[i] = load[i] ? FULL : deliver[i] ? EMPTY : state_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= EMPTY;
            end
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                if (load[i]) data_q[i] <= bus.in_data;
            end
            err_q <= take & !sel_ok;
        end
    end

    assign bus.out_valid = valid;
    assign bus.out_data  = data_q;
    assign bus.err_sel   = err_q;

`ifdef DEMUX_CNT_EN
    logic [NCH-1:0][7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.cnt_clr) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (deliver[i] && cnt_q[i] != 8'hFF) cnt_q[i] <= cnt_q[i] + 8'd1;
            end
        end
    end

    assign bus.cnt = cnt_q;
`endif
endmodule
